// File: rtl/pmem_if.sv
// 128-bit pmem line interface between a cache (master) and a memory responder (slave).
interface pmem_if;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic         pmem_resp;
  logic [127:0] pmem_rdata;
  logic         busy;
  logic         proto_err;

  modport master (
    output pmem_read, pmem_write, pmem_address, pmem_wdata,
    input  pmem_resp, pmem_rdata, busy, proto_err
  );

  modport slave (
    input  pmem_read, pmem_write, pmem_address, pmem_wdata,
    output pmem_resp, pmem_rdata, busy, proto_err
  );
endinterface

// File: rtl/pmem_responder.sv
// Responder end of the pmem line interface: accepts one line read or write,
// waits LATENCY cycles, then pulses pmem_resp. Backed by a 2**IDX_W-line store
// that survives reset.
module pmem_responder #(
  parameter int unsigned LATENCY = 4,
  parameter int unsigned IDX_W   = 6
) (
  input logic   clk,
  input logic   rst_n,
  pmem_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int unsigned LINES  = 1 << IDX_W;
  localparam logic [7:0]  LAT_M1 = 8'(LATENCY - 1);

  state_t             state;
  logic [7:0]         counter;
  logic               op_write;
  logic [IDX_W-1:0]   idx;
  logic [127:0]       wdata;
  logic [127:0]       mem [0:LINES-1];

  logic               req;
  logic [IDX_W-1:0]   req_idx;

  assign req     = bus.pmem_read | bus.pmem_write;
  assign req_idx = bus.pmem_address[IDX_W+3:4];

  // Request FSM: accept, count down the latency, pulse resp; all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      counter        <= 8'd0;
      op_write       <= 1'b0;
      idx            <= '0;
      wdata          <= 128'd0;
      bus.pmem_resp  <= 1'b0;
      bus.pmem_rdata <= 128'd0;
      bus.busy       <= 1'b0;
      bus.proto_err  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            // A simultaneous read+write is a protocol error; only the write is done.
            op_write <= bus.pmem_write;
            idx      <= req_idx;
            wdata    <= bus.pmem_wdata;
            counter  <= LAT_M1;
            bus.busy <= 1'b1;
            if (bus.pmem_read && bus.pmem_write) begin
              bus.proto_err <= 1'b1;
            end else begin
              bus.proto_err <= bus.proto_err;
            end
            if (LATENCY == 32'd1) begin
              state         <= RESP;
              bus.pmem_resp <= 1'b1;
              if (!bus.pmem_write) begin
                bus.pmem_rdata <= mem[req_idx];
              end else begin
                bus.pmem_rdata <= bus.pmem_rdata;
              end
            end else begin
              state <= WAIT;
            end
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          counter <= counter - 8'd1;
          // Counter reaches zero on this edge: next cycle is the resp cycle.
          if (counter == 8'd1) begin
            state         <= RESP;
            bus.pmem_resp <= 1'b1;
            if (!op_write) begin
              bus.pmem_rdata <= mem[idx];
            end else begin
              bus.pmem_rdata <= bus.pmem_rdata;
            end
          end else begin
            state <= WAIT;
          end
        end
        RESP: begin
          state         <= IDLE;
          counter       <= 8'd0;
          bus.pmem_resp <= 1'b0;
          bus.busy      <= 1'b0;
        end
        default: begin
          state         <= IDLE;
          counter       <= 8'd0;
          bus.pmem_resp <= 1'b0;
          bus.busy      <= 1'b0;
        end
      endcase
    end
  end

  // Line store update on the edge ending RESP; an async reset forces IDLE first, aborting it.
  always_ff @(posedge clk) begin
    if (state == RESP && op_write) begin
      mem[idx] <= wdata;
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Directed self-checking bench for pmem_responder (LATENCY=4 and LATENCY=1 instances).
module tb_pmem_responder;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  pmem_if if4 ();
  pmem_if if1 ();

  pmem_responder #(.LATENCY(4), .IDX_W(6)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
  pmem_responder #(.LATENCY(1), .IDX_W(6)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));

  localparam logic [127:0] D2  = 128'hDEAD_0000_1111_2222_3333_4444_5555_BEEF;
  localparam logic [127:0] D3  = 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978;
  localparam logic [127:0] D4A = 128'hAAAA_0001_AAAA_0002_AAAA_0003_AAAA_0004;
  localparam logic [127:0] D4B = 128'hBBBB_0001_BBBB_0002_BBBB_0003_BBBB_0004;
  localparam logic [127:0] D5  = 128'h5555_AAAA_5555_AAAA_1234_5678_9ABC_DEF0;
  localparam logic [127:0] DA  = 128'hA0A0_A0A0_A0A0_A0A0_A0A0_A0A0_A0A0_A0A1;
  localparam logic [127:0] DB  = 128'hB0B0_B0B0_B0B0_B0B0_B0B0_B0B0_B0B0_B0B2;

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr,
                       input logic [15:0] a, input logic [127:0] d);
    if (sel) begin
      if1.pmem_read = rd; if1.pmem_write = wr; if1.pmem_address = a; if1.pmem_wdata = d;
    end else begin
      if4.pmem_read = rd; if4.pmem_write = wr; if4.pmem_address = a; if4.pmem_wdata = d;
    end
  endtask

  // One complete operation; checks busy per cycle, resp cycle and the single pulse.
  task automatic op(input bit sel, input logic rd, input logic wr, input logic [15:0] a,
                    input logic [127:0] d, input bit chg, input string tag,
                    output logic [127:0] rd_o);
    int   lat;
    int   got;
    logic resp_v;
    logic busy_v;
    lat  = sel ? 1 : 4;
    got  = -1;
    rd_o = 128'd0;
    @(posedge clk); #1;
    drive(sel, rd, wr, a, d);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (chg && k == 1) drive(sel, rd, wr, 16'h0080, 128'd0);
      resp_v = sel ? if1.pmem_resp : if4.pmem_resp;
      busy_v = sel ? if1.busy : if4.busy;
      check({tag, "_busy"}, {127'd0, busy_v}, {127'd0, (k >= 1 && k <= lat)});
      if (resp_v) begin
        got  = k;
        rd_o = sel ? if1.pmem_rdata : if4.pmem_rdata;
        break;
      end
    end
    check({tag, "_resp_cycle"}, 128'(got), 128'(lat));
    @(posedge clk); #1;
    drive(sel, 1'b0, 1'b0, a, d);
    @(negedge clk);
    resp_v = sel ? if1.pmem_resp : if4.pmem_resp;
    busy_v = sel ? if1.busy : if4.busy;
    check({tag, "_one_pulse"}, {127'd0, resp_v}, 128'd0);
    check({tag, "_busy_after"}, {127'd0, busy_v}, 128'd0);
  endtask

  initial begin
    logic [127:0] r;
    checks   = 0;
    failures = 0;
    clk      = 1'b0;
    rst_n    = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 16'h0000, 128'd0);
    drive(1'b1, 1'b0, 1'b0, 16'h0000, 128'd0);
    #2 rst_n = 1'b0;
    #1;
    check("rst_resp",  {127'd0, if4.pmem_resp}, 128'd0);
    check("rst_busy",  {127'd0, if4.busy}, 128'd0);
    check("rst_rdata", if4.pmem_rdata, 128'd0);
    check("rst_perr",  {127'd0, if4.proto_err}, 128'd0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

    // Write then read back, LATENCY=4.
    op(1'b0, 1'b0, 1'b1, 16'h0040, D2, 1'b0, "wr40", r);
    op(1'b0, 1'b1, 1'b0, 16'h0040, 128'd0, 1'b0, "rd40", r);
    check("rd40_data", r, D2);

    // Reset asserted mid-WAIT of a write: outputs clear at once, no resp, no store update.
    @(posedge clk); #1 drive(1'b0, 1'b0, 1'b1, 16'h0040, 128'd0);
    @(posedge clk); @(posedge clk); #2;
    check("pre_rst_busy", {127'd0, if4.busy}, 128'd1);
    rst_n = 1'b0;
    #1;
    check("async_resp",  {127'd0, if4.pmem_resp}, 128'd0);
    check("async_busy",  {127'd0, if4.busy}, 128'd0);
    check("async_rdata", if4.pmem_rdata, 128'd0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 1'b0, 16'h0040, 128'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("no_resp_after_rst", {127'd0, if4.pmem_resp}, 128'd0);
    end
    op(1'b0, 1'b1, 1'b0, 16'h0040, 128'd0, 1'b0, "rd40_abort", r);
    check("abort_no_write", r, D2);

    // Offset bits ignored and upper address bits alias.
    op(1'b0, 1'b0, 1'b1, 16'h0123, D3, 1'b0, "wr123", r);
    op(1'b0, 1'b1, 1'b0, 16'h0120, 128'd0, 1'b0, "rd120", r);
    check("rd120_data", r, D3);
    op(1'b0, 1'b1, 1'b0, 16'h0520, 128'd0, 1'b0, "rd520", r);
    check("rd520_alias", r, D3);

    // Operand change after acceptance is ignored.
    op(1'b0, 1'b0, 1'b1, 16'h0080, D4B, 1'b0, "wr80", r);
    op(1'b0, 1'b0, 1'b1, 16'h0200, D4A, 1'b1, "wr200_chg", r);
    op(1'b0, 1'b1, 1'b0, 16'h0200, 128'd0, 1'b0, "rd200", r);
    check("latched_line", r, D4A);
    op(1'b0, 1'b1, 1'b0, 16'h0080, 128'd0, 1'b0, "rd80", r);
    check("other_line_kept", r, D4B);

    // Read and write together: sticky error, write performed.
    check("perr_before", {127'd0, if4.proto_err}, 128'd0);
    op(1'b0, 1'b1, 1'b1, 16'h0010, D5, 1'b0, "rw10", r);
    check("perr_set", {127'd0, if4.proto_err}, 128'd1);
    op(1'b0, 1'b1, 1'b0, 16'h0010, 128'd0, 1'b0, "rd10", r);
    check("rw10_data", r, D5);
    check("perr_sticky", {127'd0, if4.proto_err}, 128'd1);

    // LATENCY=1: preload two lines, then back-to-back reads.
    op(1'b1, 1'b0, 1'b1, 16'h0000, DA, 1'b0, "l1_wr0", r);
    op(1'b1, 1'b0, 1'b1, 16'h0010, DB, 1'b0, "l1_wr1", r);
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      drive(1'b1, (k < 4), 1'b0, (k < 2) ? 16'h0000 : 16'h0010, 128'd0);
      @(negedge clk);
      check("b2b_resp", {127'd0, if1.pmem_resp}, {127'd0, (k == 1 || k == 3)});
      if (k == 1) check("b2b_rdata0", if1.pmem_rdata, DA);
      if (k == 3) check("b2b_rdata1", if1.pmem_rdata, DB);
    end
    check("b2b_idle_busy", {127'd0, if1.busy}, 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
